msfsm_event_scheduler: RTL and testbench
========================================

# msfsm_event_scheduler

- Sequences output events of the synchronised Mealy FSM network (multiple synchronised FSMs) onto the physical handshake wires.
- Takes the combined (ANDed) per-event enables of all FSMs and picks one enabled event at a time, round-robin.
- Performs a four-phase req/ack with the output-wire driver, then returns a one-cycle fire pulse so every FSM advances.
- Also flags persistency violations and network deadlock.

## Interface
Parameters:
- N_EVT, 8, number of output events (e.g. x+, x-, Ro+, Ro+a, Ro-, Ro-a, Ao+, Ao-)
- GAP_CYC, 1, settling cycles after each fire before the next pick (0 allowed)
- TIMEOUT, 1024, idle cycles with no enable and no input event before deadlock is flagged

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- evt_en  in  N_EVT  combined output-event enables from the FSM network
- in_evt  in  1  any input event (Ri±, Ai±…) sampled this cycle
- hold  in  1  suppress new picks; an event in progress completes
- out_req  out  1  request to driver to perform event out_idx
- out_idx  out  $clog2(N_EVT)  index of requested event, stable while out_req=1
- out_ack  in  1  driver acknowledge (four-phase)
- evt_fire  out  N_EVT  one-hot, one-cycle pulse to all FSMs: event occurred
- busy  out  1  state ≠ IDLE
- persist_err  out  1  sticky: enable of the requested event dropped before fire
- deadlock  out  1  sticky: watchdog expired
- clr_err  in  1  synchronous clear of persist_err and deadlock

## Operation
- States: IDLE, REQ, ACK, REL, GAP.
- IDLE:
  - If !hold and |evt_en, pick the first set bit at or after ptr (wrapping).
  - Latch the pick into out_idx and go to REQ.
- REQ:
  - out_req=1.
  - On out_ack=1, go to ACK.
- ACK:
  - evt_fire[out_idx]=1 for exactly this cycle; out_req=0.
  - ptr ← out_idx+1 mod N_EVT.
  - Go to REL.
- REL:
  - Wait for out_ack=0.
  - Then go to GAP, or to IDLE if GAP_CYC=0.
- GAP: count GAP_CYC cycles, then go to IDLE.
- Persistency: while in REQ, if evt_en[out_idx]=0 in any cycle, set persist_err. The event still completes; it is never retracted.
- Watchdog:
  - Counter increments each cycle in IDLE with evt_en=0 and in_evt=0.
  - Resets to 0 on any other cycle.
  - Saturates at TIMEOUT; deadlock sets when it reaches TIMEOUT.
- clr_err clears both sticky flags; a set condition in the same cycle wins.
- hold is ignored outside IDLE.
- Reset values: state IDLE, ptr 0, out_req 0, out_idx 0, evt_fire 0, busy 0, persist_err 0, deadlock 0, watchdog counter 0.
- Reset asserted mid-handshake: the block returns to IDLE immediately. The driver must also be reset; no fire pulse is emitted.

## Timing
- Pick latency: evt_en seen in IDLE at cycle t → out_req=1 at t+1.
- out_ack=1 sampled at cycle a → evt_fire pulse at a+1 → REL from a+2.
- out_ack=0 seen at cycle r → GAP (or IDLE) from r+1.
- Minimum event period is 4+GAP_CYC cycles with a zero-delay driver.
- evt_en is sampled only in IDLE. The FSMs see evt_fire on the clock edge ending the pulse cycle, so the next pick uses post-fire enables once GAP_CYC≥1.
- Simultaneous out_ack=1 and evt_en drop in REQ: persist_err sets and the transition to ACK still occurs.
- Wrap-around: when ptr=N_EVT-1 and bit 0 is the only other enable, bit 0 is picked after N_EVT-1 is served.

## Structure
- Package msfsm_sched_pkg:
  - state enum (IDLE, REQ, ACK, REL, GAP);
  - IDX_W = $clog2(N_EVT) helper function;
  - watchdog width = $clog2(TIMEOUT+1).
- Sub-module msfsm_rr_picker: combinational round-robin first-set-bit search from ptr, returning valid and index.
- The top holds the FSM, ptr, gap counter, watchdog and sticky flags.

## Test plan
- Single event: reset release, evt_en=8'b0000_0100, driver acks after 2 cycles → out_idx=2, one evt_fire=8'b0000_0100 pulse, ptr=3, IDLE after GAP.
- Round-robin: evt_en=8'b1000_0001 held, ptr=0 → fires idx 0, then 7, then 0. Each fire is separated by ≥5 cycles (GAP_CYC=1).
- Persistency: in REQ idx 3, evt_en drops to 0 before ack → persist_err=1, fire for idx 3 still occurs. clr_err clears it.
- Hold: hold=1, evt_en=8'hFF → out_req stays 0. Hold rises during REQ → handshake completes, no new pick until hold=0.
- Deadlock: TIMEOUT=16, evt_en=0, in_evt=0 for 16 cycles → deadlock=1 at cycle 16. A single in_evt pulse at cycle 10 restarts the count.
- Reset mid-operation: assert reset while in REQ → out_req=0 asynchronously, no evt_fire, state IDLE, ptr 0.

Source files
------------

// File: rtl/msfsm_sched_pkg.sv
// Shared types and sizing helpers for the Mealy FSM network output-event scheduler.
// No logic lives here. The state enum and width functions are used by the picker and by the top.
package msfsm_sched_pkg;

  typedef enum logic [2:0] {IDLE, REQ, ACK, REL, GAP} sched_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wd_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/msfsm_rr_picker.sv
// Round-robin first-set-bit search starting at ptr and wrapping past N-1.
// Purely combinational (zero latency). It has no handshake of its own; the caller decides when to use the result.
module msfsm_rr_picker
  import msfsm_sched_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  en,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest enabled bit is assigned last and wins.
  always_comb begin
    vld = |en;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
    end
  end

endmodule

// File: rtl/msfsm_event_scheduler.sv
// Picks one enabled output event round-robin, runs a four-phase req/ack with the driver, then pulses evt_fire.
// The pick registers 1 cycle after evt_en in IDLE; out_ack stalls the handshake; hold only blocks new picks.
module msfsm_event_scheduler
  import msfsm_sched_pkg::*;
#(
  parameter int N_EVT   = 8,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = idx_w(N_EVT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EVT-1:0] evt_en,
  input  logic             in_evt,
  input  logic             hold,
  output logic             out_req,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ack,
  output logic [N_EVT-1:0] evt_fire,
  output logic             busy,
  output logic             persist_err,
  output logic             deadlock,
  input  logic             clr_err
);

  localparam int WD_W  = wd_w(TIMEOUT);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [GAP_W-1:0] gap_q;
  logic [WD_W-1:0]  wd_q;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             gap_last;
  logic             wd_idle;
  logic             persist_set;
  logic             dl_set;

  msfsm_rr_picker #(.N(N_EVT), .IW(IDX_W)) u_picker (
    .en  (evt_en),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign gap_last    = (int'(gap_q) >= GAP_CYC - 1);
  assign wd_idle     = (state_q == IDLE) && !(|evt_en) && !in_evt;
  assign persist_set = (state_q == REQ) && !evt_en[out_idx];
  assign dl_set      = wd_idle && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    out_req  = 1'b0;
    busy     = (state_q != IDLE);
    evt_fire = '0;
    case (state_q)
      IDLE: if (!hold && pick_vld) state_d = REQ;
      REQ: begin
        out_req = 1'b1;
        if (out_ack) state_d = ACK;
      end
      ACK: begin
        evt_fire = N_EVT'(1) << out_idx;
        state_d  = REL;
      end
      REL: if (!out_ack) state_d = (GAP_CYC == 0) ? IDLE : GAP;
      GAP: if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      out_idx <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == REQ) out_idx <= pick_idx;
      if (state_q == ACK)
        ptr_q <= (int'(out_idx) == N_EVT - 1) ? '0 : out_idx + IDX_W'(1);
      gap_q <= (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
    end
  end

  // Sticky flags: a set condition in the same cycle overrides clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q        <= '0;
      persist_err <= 1'b0;
      deadlock    <= 1'b0;
    end else begin
      if (!wd_idle)                      wd_q <= '0;
      else if (wd_q != WD_W'(TIMEOUT))   wd_q <= wd_q + WD_W'(1);
      if (persist_set)                   persist_err <= 1'b1;
      else if (clr_err)                  persist_err <= 1'b0;
      if (dl_set)                        deadlock <= 1'b1;
      else if (clr_err)                  deadlock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msfsm_event_scheduler.sv
// Directed bench for msfsm_event_scheduler (N_EVT=8, GAP_CYC=1, TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_msfsm_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] evt_en;
  logic       in_evt;
  logic       hold;
  logic       out_req;
  logic [2:0] out_idx;
  wire        out_ack;
  logic [7:0] evt_fire;
  logic       busy;
  logic       persist_err;
  logic       deadlock;
  logic       clr_err;

  logic auto_ack;
  logic man_ack;
  assign out_ack = auto_ack ? out_req : man_ack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  msfsm_event_scheduler #(.N_EVT(8), .GAP_CYC(1), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .evt_en      (evt_en),
    .in_evt      (in_evt),
    .hold        (hold),
    .out_req     (out_req),
    .out_idx     (out_idx),
    .out_ack     (out_ack),
    .evt_fire    (evt_fire),
    .busy        (busy),
    .persist_err (persist_err),
    .deadlock    (deadlock),
    .clr_err     (clr_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fire_val [3];
  int         fire_cyc [3];
  int         nf;

  initial begin
    reset = 1'b0; evt_en = '0; in_evt = 1'b0; hold = 1'b0;
    clr_err = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin fire_val[i] = '0; fire_cyc[i] = 0; end
    nf = 0;
    tick(); tick();
    chk("rst_out_req", out_req, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_evt_fire", evt_fire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_persist", persist_err, 0);
    chk("rst_deadlock", deadlock, 0);
    reset = 1'b1;
    tick();

    // Single event, driver acks two cycles after the request
    evt_en = 8'h04;
    tick();
    chk("single_req", out_req, 1);
    chk("single_idx", out_idx, 2);
    chk("single_busy", busy, 1);
    tick();
    chk("single_req_held", out_req, 1);
    man_ack = 1'b1;
    tick();
    chk("single_fire", evt_fire, 8'h04);
    chk("single_req_drop", out_req, 0);
    evt_en = 8'h00;
    tick();
    chk("single_fire_once", evt_fire, 0);
    chk("single_rel_busy", busy, 1);
    man_ack = 1'b0;
    tick();
    chk("single_gap_busy", busy, 1);
    tick();
    chk("single_idle", busy, 0);
    evt_en = 8'h22;  // ptr is 3, so bit 5 beats bit 1
    tick();
    chk("single_ptr3", out_idx, 5);
    man_ack = 1'b1; tick(); man_ack = 1'b0; evt_en = 8'h00;
    tick(); tick(); tick();

    // Round-robin from ptr 0 with a zero-delay driver
    reset = 1'b0; tick(); reset = 1'b1;
    evt_en = 8'h81; auto_ack = 1'b1;
    for (int c = 0; c < 40 && nf < 3; c++) begin
      tick();
      if (evt_fire != 8'h00) begin
        fire_val[nf] = evt_fire;
        fire_cyc[nf] = c;
        nf++;
      end
    end
    evt_en = 8'h00; auto_ack = 1'b0;
    chk("rr_count", nf, 3);
    chk("rr_fire0", fire_val[0], 8'h01);
    chk("rr_fire1", fire_val[1], 8'h80);
    chk("rr_fire2", fire_val[2], 8'h01);
    chk("rr_period01", fire_cyc[1] - fire_cyc[0], 5);
    chk("rr_period12", fire_cyc[2] - fire_cyc[1], 5);
    tick(); tick(); tick();
    chk("rr_idle", busy, 0);

    // Persistency: enable drops while requesting; the event still fires
    evt_en = 8'h08;
    tick();
    chk("pers_idx", out_idx, 3);
    chk("pers_clean", persist_err, 0);
    evt_en = 8'h00;
    tick();
    chk("pers_set", persist_err, 1);
    chk("pers_req_kept", out_req, 1);
    man_ack = 1'b1;
    tick();
    chk("pers_fire", evt_fire, 8'h08);
    man_ack = 1'b0;
    tick(); tick(); tick();
    chk("pers_idle", busy, 0);
    chk("pers_sticky", persist_err, 1);
    // Ack, enable drop and clr_err all together: the set wins and ACK is still entered
    evt_en = 8'h10;
    tick();
    chk("pers2_idx", out_idx, 4);
    evt_en = 8'h00; man_ack = 1'b1; clr_err = 1'b1;
    tick();
    chk("pers2_set_wins", persist_err, 1);
    chk("pers2_fire", evt_fire, 8'h10);
    man_ack = 1'b0; clr_err = 1'b0;
    tick(); tick(); tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("pers_cleared", persist_err, 0);

    // Hold blocks picks in IDLE but not a handshake already in progress
    hold = 1'b1; evt_en = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_req", out_req, 0);
    end
    hold = 1'b0;
    tick();
    chk("hold_release_idx", out_idx, 5);
    hold = 1'b1; man_ack = 1'b1;
    tick();
    chk("hold_mid_fire", evt_fire, 8'h20);
    man_ack = 1'b0;
    tick(); tick(); tick(); tick();
    chk("hold_no_repick", busy, 0);
    hold = 1'b0;
    tick();
    chk("hold_next_idx", out_idx, 6);
    man_ack = 1'b1;
    tick();
    chk("hold_next_fire", evt_fire, 8'h40);
    evt_en = 8'h00; man_ack = 1'b0;
    tick(); tick(); tick();

    // Watchdog: 9 idle cycles, an input event, then 16 idle cycles
    repeat (9) tick();
    chk("dl_early", deadlock, 0);
    in_evt = 1'b1;
    tick();
    in_evt = 1'b0;
    repeat (15) tick();
    chk("dl_restarted", deadlock, 0);
    tick();
    chk("dl_set", deadlock, 1);
    clr_err = 1'b1; in_evt = 1'b1;
    tick();
    clr_err = 1'b0; in_evt = 1'b0;
    chk("dl_cleared", deadlock, 0);

    // Reset asserted mid-handshake, after a wrap-around pick from ptr 7
    evt_en = 8'h01;
    tick();
    chk("wrap_idx", out_idx, 0);
    chk("mid_req", out_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_req", out_req, 0);
    chk("mid_async_busy", busy, 0);
    man_ack = 1'b1;
    tick();
    chk("mid_no_fire", evt_fire, 0);
    reset = 1'b1; man_ack = 1'b0; evt_en = 8'h82;
    tick();
    chk("mid_ptr0", out_idx, 1);
    man_ack = 1'b1;
    tick();
    chk("mid_after_fire", evt_fire, 8'h02);
    man_ack = 1'b0; evt_en = 8'h00;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
